// File: rtl/dav_capture_pkg.sv
// Shared types and default parameters for the sample
// capture controller and its tick generator.
package dav_capture_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CAPTURE,
    S_HANDOFF,
    S_WAIT_FFT
  } state_t;

  localparam int DEF_POINTS  = 64;
  localparam int DEF_CLK_DIV = 1000;

endpackage

// File: rtl/sample_tick_gen.sv
// Sample-rate divider: counts 0..CLK_DIV-1 while enabled
// and flags the terminal count as a tick.
module sample_tick_gen
  import dav_capture_pkg::*;
#(
  parameter int CLK_DIV = DEF_CLK_DIV
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int CW = $clog2(CLK_DIV);

  logic [CW-1:0] cnt;

  assign tick = (cnt == CW'(CLK_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= tick ? '0 : cnt + CW'(1);
    end
  end

endmodule

// File: rtl/sample_capture_ctrl.sv
// Frame capture FSM: paces buffer writes from vsync,
// hands full frames to the FFT and counts lost frames.
module sample_capture_ctrl
  import dav_capture_pkg::*;
#(
  parameter int POINTS  = DEF_POINTS,
  parameter int CLK_DIV = DEF_CLK_DIV
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      vsync,
  input  logic                      fft_done,
  output logic                      wr_en,
  output logic [$clog2(POINTS)-1:0] wr_addr,
  output logic                      fft_start,
  output logic                      busy,
  output logic [7:0]                drop_count
);

  localparam int AW = $clog2(POINTS);

  state_t state;
  state_t state_nx;
  logic   vsync_q;
  logic   rise;
  logic   tick;
  logic   last;
  logic   wr_nx;
  logic   drop_inc;
  logic   div_en;
  logic   div_clr;

  assign rise    = vsync & ~vsync_q;
  assign last    = (wr_addr == AW'(POINTS - 1));
  assign div_en  = (state == S_CAPTURE);
  assign div_clr = (state != S_CAPTURE);
  assign busy    = (state != S_IDLE);

  sample_tick_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_tick (
    .clk   (clk),
    .rst   (rst),
    .clear (div_clr),
    .enable(div_en),
    .tick  (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // wr_en is the registered tick, so a frame aborts only
  // when vsync falls on a cycle that is not itself a write.
  always_comb begin
    state_nx = state;
    wr_nx    = 1'b0;
    drop_inc = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (rise) state_nx = S_CAPTURE;
      end
      S_CAPTURE: begin
        if (wr_en && last) begin
          state_nx = S_HANDOFF;
        end else if (!vsync && !wr_en) begin
          state_nx = S_IDLE;
          drop_inc = 1'b1;
        end else begin
          wr_nx = tick;
        end
      end
      S_HANDOFF: begin
        state_nx = S_WAIT_FFT;
        drop_inc = rise;
      end
      S_WAIT_FFT: begin
        drop_inc = rise;
        if (fft_done) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vsync_q    <= 1'b1;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      fft_start  <= 1'b0;
      drop_count <= 8'd0;
    end else begin
      vsync_q   <= vsync;
      wr_en     <= wr_nx;
      fft_start <= (state == S_HANDOFF);
      if (state == S_IDLE)  wr_addr <= '0;
      else if (wr_en)       wr_addr <= wr_addr + AW'(1);
      if (drop_inc && drop_count != 8'hFF)
        drop_count <= drop_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_sample_capture_ctrl.sv
// Directed bench for sample_capture_ctrl with POINTS=4,
// CLK_DIV=3; cycle 0 is the cycle vsync first rises.
module tb_sample_capture_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       vsync;
  logic       fft_done;
  logic       wr_en;
  logic [1:0] wr_addr;
  logic       fft_start;
  logic       busy;
  logic [7:0] drop_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sample_capture_ctrl #(
    .POINTS (4),
    .CLK_DIV(3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .vsync     (vsync),
    .fft_done  (fft_done),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .fft_start (fft_start),
    .busy      (busy),
    .drop_count(drop_count)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic reset_dut();
    rst      = 1'b1;
    vsync    = 1'b0;
    fft_done = 1'b0;
    step();
    rst = 1'b0;
    step();
  endtask

  // One frame from the rise; vsync falls at cycle drop_at.
  task automatic run_frame(input int drop_at);
    for (int c = 0; c < 18; c++) begin
      logic we;
      vsync = (c < drop_at);
      we = (c == 4 || c == 7 || c == 10 || c == 13);
      chk($sformatf("wr_en c%0d", c), 32'(wr_en), 32'(we));
      chk($sformatf("fft_start c%0d", c),
          32'(fft_start), 32'(c == 15));
      chk($sformatf("busy c%0d", c), 32'(busy), 32'(c != 0));
      if (we)
        chk($sformatf("wr_addr c%0d", c),
            32'(wr_addr), 32'((c - 4) / 3));
      step();
    end
  endtask

  initial begin
    rst      = 1'b1;
    vsync    = 1'b1;
    fft_done = 1'b0;
    step();
    step();
    chk("rst wr_en", 32'(wr_en), 0);
    chk("rst wr_addr", 32'(wr_addr), 0);
    chk("rst fft_start", 32'(fft_start), 0);
    chk("rst busy", 32'(busy), 0);
    chk("rst drop", 32'(drop_count), 0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("no spurious rise", 32'(busy), 0);
    end

    // full frame, vsync held high
    reset_dut();
    run_frame(100);
    chk("frame drop", 32'(drop_count), 0);
    fft_done = 1'b1;
    step();
    fft_done = 1'b0;
    chk("frame done idle", 32'(busy), 0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("level no start", 32'(busy), 0);
    end

    // abort mid-frame at cycle 8
    reset_dut();
    for (int c = 0; c < 21; c++) begin
      vsync = (c < 8);
      chk($sformatf("abort wr_en c%0d", c),
          32'(wr_en), 32'(c == 4 || c == 7));
      chk("abort fft_start", 32'(fft_start), 0);
      if (c == 9) begin
        chk("abort idle", 32'(busy), 0);
        chk("abort drop", 32'(drop_count), 1);
      end
      step();
    end

    // vsync falls on the final write
    reset_dut();
    run_frame(13);
    chk("late fall drop", 32'(drop_count), 0);
    chk("late fall wait", 32'(busy), 1);
    fft_done = 1'b1;
    step();
    fft_done = 1'b0;
    chk("late fall idle", 32'(busy), 0);

    // second rise while waiting on the FFT
    reset_dut();
    run_frame(100);
    vsync = 1'b0;
    step();
    vsync = 1'b1;
    step();
    chk("wait rise drop", 32'(drop_count), 1);
    chk("wait rise busy", 32'(busy), 1);
    fft_done = 1'b1;
    step();
    fft_done = 1'b0;
    chk("wait done idle", 32'(busy), 0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("wait no start", 32'(busy), 0);
      chk("wait no wr", 32'(wr_en), 0);
    end
    vsync = 1'b0;
    step();
    vsync = 1'b1;
    step();
    chk("new rise busy", 32'(busy), 1);
    fft_done = 1'b1;
    step();
    fft_done = 1'b0;
    chk("fft_done ignored", 32'(busy), 1);
    chk("fft_done drop", 32'(drop_count), 1);

    // reset during capture at wr_addr 2
    reset_dut();
    vsync = 1'b1;
    for (int i = 0; i < 9; i++) step();
    chk("pre rst addr", 32'(wr_addr), 2);
    rst = 1'b1;
    step();
    chk("mid rst busy", 32'(busy), 0);
    chk("mid rst addr", 32'(wr_addr), 0);
    chk("mid rst wr_en", 32'(wr_en), 0);
    chk("mid rst drop", 32'(drop_count), 0);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      chk("post rst busy", 32'(busy), 0);
      chk("post rst fft", 32'(fft_start), 0);
    end

    // 300 aborted frames saturate the counter
    reset_dut();
    for (int i = 0; i < 300; i++) begin
      vsync = 1'b1;
      step();
      vsync = 1'b0;
      step();
      if (i == 253) chk("drop 254", 32'(drop_count), 254);
      if (i == 254) chk("drop 255", 32'(drop_count), 255);
    end
    chk("drop sat", 32'(drop_count), 255);
    chk("sat idle", 32'(busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
